// File: rtl/fibonacci_index.sv
// rtl/fibonacci_index.sv - Fibonacci index finder: returns the index of f_in, or its floor index on a miss
// Optional build macro FIBONACCI_INDEX_NEAREST_EN: a miss reports the index of the nearest Fibonacci number
// (ties resolve to the lower index) instead of the floor index.
module fibonacci_index #(
   parameter int W  = 20,
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  f_in,
   output logic          ready,
   output logic          done_tick,
   output logic [IW-1:0] idx,
   output logic          is_fib
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q,  state_d;
   logic [W-1:0]  target_q, target_d;
   logic [W:0]    t0_q,     t0_d;
   logic [W:0]    t1_q,     t1_d;
   logic [IW-1:0] n_q,      n_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic          is_fib_q, is_fib_d;

   // Target widened to the running-term width so comparisons never truncate t1
   logic [W:0]    target_ext;
   logic [IW-1:0] miss_idx;

   assign target_ext = {1'b0, target_q};

`ifdef FIBONACCI_INDEX_NEAREST_EN
   // On a miss t0 < target < t1, so both distances are positive; a tie picks the lower index
   logic [W:0] d_lo;
   logic [W:0] d_hi;
   assign d_lo     = target_ext - t0_q;
   assign d_hi     = t1_q - target_ext;
   assign miss_idx = (d_hi < d_lo) ? n_q : (n_q - 1'b1);
`else
   // Floor index: t1 overshot, so the previous term is the largest one below target
   assign miss_idx = n_q - 1'b1;
`endif

   // Next-state and datapath: one Fibonacci step or one termination decision per OP cycle
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      t0_d     = t0_q;
      t1_d     = t1_q;
      n_d      = n_q;
      idx_d    = idx_q;
      is_fib_d = is_fib_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = f_in;
               t0_d     = '0;
               t1_d     = {{W{1'b0}}, 1'b1};
               n_d      = {{(IW-1){1'b0}}, 1'b1};
               state_d  = S_OP;
            end
         end
         S_OP: begin
            if (target_q == '0) begin
               idx_d    = '0;
               is_fib_d = 1'b1;
               state_d  = S_DONE;
            end else if (t1_q == target_ext) begin
               idx_d    = n_q;
               is_fib_d = 1'b1;
               state_d  = S_DONE;
            end else if (t1_q > target_ext) begin
               idx_d    = miss_idx;
               is_fib_d = 1'b0;
               state_d  = S_DONE;
            end else begin
               t0_d = t1_q;
               t1_d = t0_q + t1_q;
               n_d  = n_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any request in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         t0_q     <= '0;
         t1_q     <= '0;
         n_q      <= '0;
         idx_q    <= '0;
         is_fib_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         t0_q     <= t0_d;
         t1_q     <= t1_d;
         n_q      <= n_d;
         idx_q    <= idx_d;
         is_fib_q <= is_fib_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign done_tick = (state_q == S_DONE);
   assign idx       = idx_q;
   assign is_fib    = is_fib_q;

endmodule
